// File: rtl/mem_arbiter.sv
// Shares one 128-bit line-wide memory port between the I-cache and D-cache.
// One transaction at a time; a D write-back stays atomic with its allocate read.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [DATA_W-1:0] i_mem_wdata,
    output logic              i_mem_ready,
    output logic [DATA_W-1:0] i_mem_rdata,

    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic              d_mem_ready,
    output logic [DATA_W-1:0] d_mem_rdata,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]        state;
    logic              last;      // 1: D was granted last, 0: I was granted last
    logic              lock;      // set for the IDLE cycle right after a D write-back
    logic              grant_d;

    logic              i_act;
    logic              d_act;
    logic              pick_d;
    logic              sel_read;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Winner selection; read+write together is treated as a write.
    always_comb begin
        i_act     = i_mem_read | i_mem_write;
        d_act     = d_mem_read | d_mem_write;
        pick_d    = d_act & (~i_act | lock | ~last);
        sel_write = pick_d ? d_mem_write : i_mem_write;
        sel_read  = (pick_d ? d_mem_read : i_mem_read) & ~sel_write;
        sel_addr  = pick_d ? d_mem_addr  : i_mem_addr;
        sel_wdata = pick_d ? d_mem_wdata : i_mem_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= 1'b0;
            lock      <= 1'b0;
            grant_d   <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (state == IDLE) begin
            lock <= 1'b0;
            if (i_act | d_act) begin
                state     <= BUSY;
                mem_read  <= sel_read;
                mem_write <= sel_write;
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
                grant_d   <= pick_d;
                last      <= pick_d;
            end
        end else begin
            // Bus held stable until completion; the turnaround cycle follows.
            if (mem_ready) begin
                state     <= IDLE;
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
                mem_addr  <= '0;
                lock      <= grant_d & mem_write;
            end
        end
    end

    assign i_mem_ready = mem_ready & (state == BUSY) & ~grant_d;
    assign d_mem_ready = mem_ready & (state == BUSY) &  grant_d;
    assign i_mem_rdata = mem_rdata;
    assign d_mem_rdata = mem_rdata;

endmodule
